// File: rtl/can_tx_arbiter.sv
// can_tx_arbiter
// Selects one of three CAN frame requesters, latches its identifier and
// payload, and sequences the CAN transmit block through start, transmit,
// completion and an inter-frame gap. Lowest identifier wins. Ties go to the
// lowest requester index.
//
// Ports
//   clk                 system clock
//   rst                 asynchronous reset, active high
//   req[2:0]            level request per requester
//   id0..id2 [10:0]     CAN identifier per requester
//   data0..data2 [63:0] payload per requester
//   txing               busy flag from the CAN transmit block
//   tx_start            start request to the CAN transmit block
//   tx_address [10:0]   latched identifier of the granted frame
//   tx_data [63:0]      latched payload of the granted frame
//   grant[2:0]          one-hot owner of the current frame
//   ack[2:0]            one-cycle pulse on successful completion
//   err[2:0]            one-cycle pulse on start or frame timeout
//   busy                high whenever the FSM is not idle
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | arbitrate among active requests, latch the winner
// START     | tx_start held high until txing rises or start timeout
// WAIT_DONE | frame on the bus; wait for txing to fall or frame timeout
// COMPLETE  | ack pulse is visible for this single cycle
// GAP       | grant cleared, inter-frame idle count, then back to IDLE
module can_tx_arbiter #(
    parameter int unsigned START_TIMEOUT = 1000,
    parameter int unsigned FRAME_TIMEOUT = 2000000,
    parameter int unsigned IFS_CYCLES    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [10:0] id0,
    input  logic [10:0] id1,
    input  logic [10:0] id2,
    input  logic [63:0] data0,
    input  logic [63:0] data1,
    input  logic [63:0] data2,
    input  logic        txing,
    output logic        tx_start,
    output logic [10:0] tx_address,
    output logic [63:0] tx_data,
    output logic [2:0]  grant,
    output logic [2:0]  ack,
    output logic [2:0]  err,
    output logic        busy
);

    if (START_TIMEOUT >= (1 << 24) || FRAME_TIMEOUT >= (1 << 24) ||
        IFS_CYCLES >= (1 << 24) || START_TIMEOUT == 0 ||
        FRAME_TIMEOUT == 0 || IFS_CYCLES == 0) begin : g_bad_param
        $error("can_tx_arbiter: timing parameters must be in 1 .. 2^24-1");
    end

    localparam logic [23:0] START_LAST = 24'(START_TIMEOUT - 1);
    localparam logic [23:0] FRAME_LAST = 24'(FRAME_TIMEOUT - 1);
    localparam logic [23:0] IFS_LAST   = 24'(IFS_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_COMPLETE,
        S_GAP
    } state_t;

    state_t      state;
    logic [23:0] timer;
    logic [23:0] timer_inc;

    logic        sel_valid;
    logic [1:0]  sel_idx;
    logic [10:0] sel_id;
    logic [63:0] sel_data;

    // Saturating increment: the timer sticks at all-ones instead of wrapping.
    assign timer_inc = (timer == 24'hFF_FFFF) ? timer : timer + 24'd1;

    // Strict less-than keeps the lower index on equal identifiers.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = 2'd0;
        sel_id    = 11'd0;
        sel_data  = 64'd0;
        if (req[0]) begin
            sel_valid = 1'b1;
            sel_idx   = 2'd0;
            sel_id    = id0;
            sel_data  = data0;
        end
        if (req[1] && (!sel_valid || id1 < sel_id)) begin
            sel_valid = 1'b1;
            sel_idx   = 2'd1;
            sel_id    = id1;
            sel_data  = data1;
        end
        if (req[2] && (!sel_valid || id2 < sel_id)) begin
            sel_valid = 1'b1;
            sel_idx   = 2'd2;
            sel_id    = id2;
            sel_data  = data2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            timer      <= 24'd0;
            tx_start   <= 1'b0;
            tx_address <= 11'd0;
            tx_data    <= 64'd0;
            grant      <= 3'b000;
            ack        <= 3'b000;
            err        <= 3'b000;
            busy       <= 1'b0;
        end else begin
            ack <= 3'b000;
            err <= 3'b000;
            unique case (state)
                S_IDLE: begin
                    if (sel_valid) begin
                        tx_address <= sel_id;
                        tx_data    <= sel_data;
                        grant      <= 3'b001 << sel_idx;
                        timer      <= 24'd0;
                        tx_start   <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    if (txing) begin
                        tx_start <= 1'b0;
                        timer    <= 24'd0;
                        state    <= S_WAIT_DONE;
                    end else if (timer == START_LAST) begin
                        err      <= grant;
                        tx_start <= 1'b0;
                        grant    <= 3'b000;
                        timer    <= 24'd0;
                        state    <= S_GAP;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                S_WAIT_DONE: begin
                    // ack is raised here so it is visible one cycle after txing falls.
                    if (!txing) begin
                        ack   <= grant;
                        state <= S_COMPLETE;
                    end else if (timer == FRAME_LAST) begin
                        err   <= grant;
                        grant <= 3'b000;
                        timer <= 24'd0;
                        state <= S_GAP;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                S_COMPLETE: begin
                    grant <= 3'b000;
                    timer <= 24'd0;
                    state <= S_GAP;
                end
                S_GAP: begin
                    if (timer == IFS_LAST) begin
                        busy  <= 1'b0;
                        timer <= 24'd0;
                        state <= S_IDLE;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    grant    <= 3'b000;
                    busy     <= 1'b0;
                    timer    <= 24'd0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_can_tx_arbiter.sv
// Testbench for can_tx_arbiter: directed scenarios plus randomized traffic,
// with a timestamp-based reference model checked every cycle.
module tb_can_tx_arbiter;

    localparam int ST  = 20;
    localparam int FT  = 300;
    localparam int IFS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [10:0] id_a [3];
    logic [63:0] dat_a [3];
    logic        txing = 1'b0;
    logic        tx_start;
    logic [10:0] tx_address;
    logic [63:0] tx_data;
    logic [2:0]  grant, ack, err;
    logic        busy;

    always #5 clk = ~clk;

    can_tx_arbiter #(.START_TIMEOUT(ST), .FRAME_TIMEOUT(FT), .IFS_CYCLES(IFS)) dut (
        .clk(clk), .rst(rst), .req(req),
        .id0(id_a[0]), .id1(id_a[1]), .id2(id_a[2]),
        .data0(dat_a[0]), .data1(dat_a[1]), .data2(dat_a[2]),
        .txing(txing), .tx_start(tx_start), .tx_address(tx_address),
        .tx_data(tx_data), .grant(grant), .ack(ack), .err(err), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model (timestamps, not a timer) ----------------
    localparam int M_IDLE = 0, M_START = 1, M_SEND = 2, M_ACK = 3, M_GAP = 4;
    int          m_mode = M_IDLE;
    int          m_owner = 0;
    int          m_cyc = 0;
    int          m_t0 = 0;
    logic        e_tx_start = 1'b0;
    logic [10:0] e_addr = 11'd0;
    logic [63:0] e_data = 64'd0;
    logic [2:0]  e_grant = 3'b000, e_ack = 3'b000, e_err = 3'b000;
    logic        e_busy = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE; e_tx_start = 0; e_addr = 0; e_data = 0;
            e_grant = 0; e_ack = 0; e_err = 0; e_busy = 0;
        end else begin
            m_cyc++;
            e_ack = 0;
            e_err = 0;
            case (m_mode)
                M_IDLE: begin
                    int best;
                    int key;
                    best = -1;
                    // winner = smallest (id, index) pair read as one number
                    for (int i = 0; i < 3; i++) begin
                        key = int'(id_a[i]) * 4 + i;
                        if (req[i] && (best < 0 || key < best)) best = key;
                    end
                    if (best >= 0) begin
                        m_owner = best % 4;
                        e_addr = id_a[m_owner];
                        e_data = dat_a[m_owner];
                        e_grant = 3'(1 << m_owner);
                        e_tx_start = 1; e_busy = 1;
                        m_mode = M_START; m_t0 = m_cyc;
                    end
                end
                M_START: begin
                    if (txing) begin
                        e_tx_start = 0; m_mode = M_SEND; m_t0 = m_cyc;
                    end else if (m_cyc - m_t0 == ST) begin
                        e_err = 3'(1 << m_owner); e_tx_start = 0; e_grant = 0;
                        m_mode = M_GAP; m_t0 = m_cyc;
                    end
                end
                M_SEND: begin
                    if (!txing) begin
                        e_ack = 3'(1 << m_owner); m_mode = M_ACK;
                    end else if (m_cyc - m_t0 == FT) begin
                        e_err = 3'(1 << m_owner); e_grant = 0;
                        m_mode = M_GAP; m_t0 = m_cyc;
                    end
                end
                M_ACK: begin
                    e_grant = 0; m_mode = M_GAP; m_t0 = m_cyc;
                end
                default: begin
                    if (m_cyc - m_t0 == IFS) begin
                        e_busy = 0; m_mode = M_IDLE;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("tx_start", 64'(tx_start), 64'(e_tx_start));
            chk("tx_address", 64'(tx_address), 64'(e_addr));
            chk("tx_data", tx_data, e_data);
            chk("grant", 64'(grant), 64'(e_grant));
            chk("ack", 64'(ack), 64'(e_ack));
            chk("err", 64'(err), 64'(e_err));
            chk("busy", 64'(busy), 64'(e_busy));
        end
    end

    // ---------------- event log ----------------
    int         mon_cyc = 0;
    logic [2:0] pg = 3'b000;
    logic       pts = 1'b0;
    int         ts_cnt = 0;
    logic [2:0] g_val_q[$], ack_val_q[$], err_val_q[$];
    int         g_cyc_q[$], gf_cyc_q[$], ack_cyc_q[$], err_cyc_q[$];
    int         ts_rise_q[$], ts_fall_q[$];

    always @(negedge clk) begin
        mon_cyc++;
        if (!rst) begin
            if (grant != 0 && pg == 0) begin g_val_q.push_back(grant); g_cyc_q.push_back(mon_cyc); end
            if (grant == 0 && pg != 0) gf_cyc_q.push_back(mon_cyc);
            if (ack != 0) begin ack_val_q.push_back(ack); ack_cyc_q.push_back(mon_cyc); end
            if (err != 0) begin err_val_q.push_back(err); err_cyc_q.push_back(mon_cyc); end
            if (tx_start) ts_cnt++;
            if (tx_start && !pts) ts_rise_q.push_back(mon_cyc);
            if (!tx_start && pts) ts_fall_q.push_back(mon_cyc);
        end
        pg = grant;
        pts = tx_start;
    end

    task automatic clear_log();
        g_val_q.delete(); ack_val_q.delete(); err_val_q.delete();
        g_cyc_q.delete(); gf_cyc_q.delete(); ack_cyc_q.delete(); err_cyc_q.delete();
        ts_rise_q.delete(); ts_fall_q.delete();
        ts_cnt = 0;
    endtask

    // ---------------- stimulus ----------------
    logic auto_drop = 1'b1;
    logic resp_on = 1'b0;
    logic rand_on = 1'b0;
    int   resp_delay = 0, resp_len = 0, rd_cnt = 0, rl_cnt = 0;
    int   drv_fall_cyc = 0;

    task automatic tick();
        @(negedge clk);
        #1;
        if (auto_drop) req = req & ~(ack | err);
        if (rand_on && !busy && !txing) begin
            resp_delay = $urandom_range(0, ST + 3);
            resp_len = ($urandom_range(0, 9) == 0) ? FT + 20 : $urandom_range(0, 30);
        end
        if (resp_on) begin
            if (txing) begin
                if (rl_cnt <= 0) begin txing = 0; drv_fall_cyc = mon_cyc; end
                else rl_cnt--;
            end else if (tx_start) begin
                if (rd_cnt <= 0) begin txing = 1; rl_cnt = resp_len; end
                else rd_cnt--;
            end else begin
                rd_cnt = resp_delay;
            end
        end
        if (rand_on) begin
            for (int i = 0; i < 3; i++) begin
                if (!req[i] && $urandom_range(0, 5) == 0) begin
                    req[i] = 1'b1;
                    id_a[i] = 11'($urandom_range(0, 7));
                    dat_a[i] = {$urandom, $urandom};
                end else if (req[i] && $urandom_range(0, 199) == 0) begin
                    req[i] = 1'b0;
                end else if ($urandom_range(0, 9) == 0) begin
                    id_a[i] = 11'($urandom_range(0, 7));
                    dat_a[i] = {$urandom, $urandom};
                end
            end
        end
    endtask

    function automatic int qsize(input int which);
        case (which)
            0: return ack_cyc_q.size();
            1: return err_cyc_q.size();
            2: return ts_fall_q.size();
            default: return g_cyc_q.size();
        endcase
    endfunction

    task automatic wait_count(input int which, input int n, input int budget, input string name);
        int k;
        k = 0;
        while (k < budget && qsize(which) < n) begin tick(); k++; end
        if (qsize(which) < n) begin
            n_checks++; n_errors++;
            $display("FAIL %s timeout: events=%0d required=%0d", name, qsize(which), n);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (k < budget && (busy || req != 0)) begin tick(); k++; end
        if (busy) begin
            n_checks++; n_errors++;
            $display("FAIL idle_timeout: busy=%0d required=0", busy);
        end
        tick();
    endtask

    initial begin
        int req_rise;
        for (int i = 0; i < 3; i++) begin id_a[i] = 0; dat_a[i] = 0; end
        tick(); tick();
        chk("reset_tx_start", 64'(tx_start), 64'd0);
        chk("reset_grant", 64'(grant), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_tx_data", tx_data, 64'd0);
        rst = 1'b0;
        tick();

        // Single frame, txing after 5 cycles of tx_start, 100 cycles on the bus.
        clear_log();
        resp_on = 1; resp_delay = 4; resp_len = 99;
        id_a[0] = 11'h010; dat_a[0] = 64'hA5A5_A5A5_A5A5_A5A5;
        tick();
        req = 3'b001; req_rise = mon_cyc;
        wait_count(0, 1, 300, "t1_ack");
        if (ack_cyc_q.size() == 1) begin
            chk("t1_tx_start_cycles", 64'(ts_cnt), 64'd5);
            chk("t1_start_latency", 64'(ts_rise_q[0] - req_rise), 64'd1);
            chk("t1_ack_val", 64'(ack_val_q[0]), 64'b001);
            chk("t1_ack_latency", 64'(ack_cyc_q[0] - drv_fall_cyc), 64'd1);
            chk("t1_tx_data", tx_data, 64'hA5A5_A5A5_A5A5_A5A5);
            chk("t1_tx_address", 64'(tx_address), 64'h010);
            chk("t1_no_err", 64'(err_cyc_q.size()), 64'd0);
        end
        wait_idle(100);

        // Three simultaneous requests with a tie on the lowest id.
        clear_log();
        resp_delay = 1; resp_len = 10;
        id_a[0] = 11'h020; id_a[1] = 11'h005; id_a[2] = 11'h005;
        dat_a[0] = 64'h1111; dat_a[1] = 64'h2222; dat_a[2] = 64'h3333;
        tick();
        req = 3'b111;
        wait_count(0, 3, 500, "t2_acks");
        if (g_val_q.size() == 3 && gf_cyc_q.size() >= 2) begin
            chk("t2_grant_0", 64'(g_val_q[0]), 64'b010);
            chk("t2_grant_1", 64'(g_val_q[1]), 64'b100);
            chk("t2_grant_2", 64'(g_val_q[2]), 64'b001);
            chk("t2_gap_01", 64'(g_cyc_q[1] - gf_cyc_q[0]), 64'(IFS + 1));
            chk("t2_gap_12", 64'(g_cyc_q[2] - gf_cyc_q[1]), 64'(IFS + 1));
        end else begin
            chk("t2_grant_count", 64'(g_val_q.size()), 64'd3);
        end
        wait_idle(100);

        // txing never rises: start timeout, then the next requester after the gap.
        clear_log();
        resp_on = 0; txing = 0;
        id_a[0] = 11'h001; id_a[1] = 11'h002;
        tick();
        req = 3'b011;
        wait_count(1, 2, 200, "t3_errs");
        if (err_cyc_q.size() == 2 && g_cyc_q.size() == 2) begin
            chk("t3_err_val", 64'(err_val_q[0]), 64'b001);
            chk("t3_err_delay", 64'(err_cyc_q[0] - g_cyc_q[0]), 64'(ST));
            chk("t3_next_grant", 64'(g_cyc_q[1] - err_cyc_q[0]), 64'(IFS + 1));
            chk("t3_no_ack", 64'(ack_cyc_q.size()), 64'd0);
        end
        wait_idle(100);

        // txing stuck high: frame timeout.
        clear_log();
        resp_on = 1; resp_delay = 2; resp_len = 1000;
        id_a[2] = 11'h123;
        tick();
        req = 3'b100;
        wait_count(1, 1, 600, "t4_err");
        if (err_cyc_q.size() == 1 && ts_fall_q.size() == 1) begin
            chk("t4_err_val", 64'(err_val_q[0]), 64'b100);
            chk("t4_err_delay", 64'(err_cyc_q[0] - ts_fall_q[0]), 64'(FT));
            chk("t4_no_ack", 64'(ack_cyc_q.size()), 64'd0);
        end
        resp_on = 0; txing = 0;
        wait_idle(100);

        // Reset during WAIT_DONE, request regranted after release.
        clear_log();
        resp_on = 1; resp_delay = 2; resp_len = 60;
        id_a[0] = 11'h044; dat_a[0] = 64'hDEAD_BEEF_0000_0001;
        tick();
        req = 3'b001;
        wait_count(2, 1, 50, "t5_wait_done");
        for (int k = 0; k < 10; k++) tick();
        rst = 1;
        #1;
        chk("t5_rst_tx_start", 64'(tx_start), 64'd0);
        chk("t5_rst_grant", 64'(grant), 64'd0);
        chk("t5_rst_ack_err", 64'({ack, err}), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_tx_address", 64'(tx_address), 64'd0);
        chk("t5_rst_tx_data", tx_data, 64'd0);
        txing = 0;
        tick();
        tick();
        clear_log();
        rst = 0;
        tick();
        chk("t5_regrant", 64'(grant), 64'b001);
        chk("t5_regrant_start", 64'(tx_start), 64'd1);
        wait_count(0, 1, 200, "t5_ack");
        chk("t5_no_err", 64'(err_cyc_q.size()), 64'd0);
        wait_idle(100);

        // Owner drops req mid-frame while a lower-id request arrives.
        clear_log();
        resp_delay = 2; resp_len = 40;
        id_a[0] = 11'h030;
        tick();
        req = 3'b001;
        wait_count(2, 1, 50, "t6_wait_done");
        for (int k = 0; k < 5; k++) tick();
        id_a[1] = 11'h005;
        req = 3'b010;
        wait_count(0, 2, 300, "t6_acks");
        if (ack_cyc_q.size() == 2 && g_val_q.size() == 2) begin
            chk("t6_ack0", 64'(ack_val_q[0]), 64'b001);
            chk("t6_grant1", 64'(g_val_q[1]), 64'b010);
            chk("t6_grant1_delay", 64'(g_cyc_q[1] - ack_cyc_q[0]), 64'(IFS + 2));
        end
        wait_idle(100);

        // Randomized traffic against the reference model.
        rand_on = 1;
        for (int k = 0; k < 4000; k++) tick();
        rand_on = 0;
        tick();
        req = 3'b000;
        wait_idle(1000);
        resp_on = 0; txing = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
